conv_window_reader: RTL and testbench
=====================================

Name: conv_window_reader

Overview:
- Read-side initiator for the team's single-port-style RAM: image buffer with `en`/`wr`/`address_rd`, registered `dout`, 1-cycle read latency.
- After `start`, walks every KxK convolution window of an IMG_W x IMG_H image stored row-major in that RAM.
- Issues RAM reads and streams the window pixels out on a valid/ready interface to the MAC datapath.
- Throughput is one pixel per cycle under full backpressure support.

Parameters:
- DATA_WIDTH, 8, pixel width; equals the RAM word width.
- ADDR_WIDTH, 6, RAM address width; IMG_W*IMG_H <= 2**ADDR_WIDTH.
- IMG_W, 8, image width in pixels.
- IMG_H, 8, image height in pixels.
- K, 3, kernel size; K <= IMG_W and K <= IMG_H.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle pulse; begin a frame scan; ignored while busy=1.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last pixel handshake.
- ram_en  out  1  RAM enable; high only in cycles that issue a read.
- ram_wr  out  1  constant 0; this block never writes.
- ram_address_rd  out  ADDR_WIDTH  RAM read address.
- ram_dout  in  DATA_WIDTH  RAM read data; valid one cycle after ram_en=1.
- pix_valid  out  1  pix_data valid.
- pix_ready  in  1  downstream accept.
- pix_data  out  DATA_WIDTH  window pixel.
- pix_first  out  1  first tap (ky=0, kx=0) of a window.
- pix_last  out  1  last tap (ky=K-1, kx=K-1) of a window.

Behaviour:
- Reset values: busy=0, done=0, ram_en=0, ram_address_rd=0, pix_valid=0, pix_data=0, pix_first=0, pix_last=0, FSM=IDLE, all counters 0.
- Reset mid-frame aborts the scan; in-flight RAM data and buffered pixels are discarded.
- FSM states:
  - IDLE: start=1 -> RUN; clear counters oy, ox, ky, kx.
  - RUN: issues one read per cycle when credit allows. After the read for (oy=IMG_H-K, ox=IMG_W-K, ky=K-1, kx=K-1) is issued -> DRAIN.
  - DRAIN: no reads; when in-flight=0 and the buffer is empty -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Scan order:
  - Windows in raster order: oy outer, ox inner.
  - Taps within a window in raster order: ky outer, kx inner.
  - Address = (oy+ky)*IMG_W + (ox+kx), truncated to ADDR_WIDTH.
  - Counters wrap kx -> ky -> ox -> oy.
  - Outputs per frame: (IMG_W-K+1)*(IMG_H-K+1) windows of K*K beats each.
- Credit rule:
  - Issue a read (ram_en=1) in cycle t only if buffer occupancy + in-flight reads (0 or 1) < 2, counting a pop in cycle t.
  - Data captured from ram_dout at t+1 is pushed into a 2-entry FIFO together with its first/last tags.
  - Gives no bubble when pix_ready=1 and no data loss under arbitrary pix_ready.
- Output stream:
  - pix_valid = FIFO not empty.
  - Payload (pix_data, pix_first, pix_last) holds stable while pix_valid=1 and pix_ready=0.
- Latency: start -> first pix_valid = 3 cycles (start registered, read issued, data pushed).
- Boundaries:
  - K=IMG_W gives exactly one window column.
  - start is ignored when busy=1 or done=1.
  - start arriving in the same cycle as the done pulse is ignored.
  - pix_ready=1 with pix_valid=0 has no effect.

Optional Feature:
- CONV_WIN_ZERO_PAD_EN: "same" convolution with zero padding.
  - Windows are centred on every pixel: IMG_W*IMG_H windows.
  - Tap coordinate = (oy+ky-(K-1)/2, ox+kx-(K-1)/2).
  - Out-of-image taps issue no RAM read (ram_en=0). They still occupy a pipeline slot tagged "pad", so they stay in order and pix_data=0 for them.
- Without the macro: valid-only windows as above; no pad logic present.

Decomposition:
- Package conv_pkg holds:
  - fsm state enum: IDLE/RUN/DRAIN/DONE.
  - pixel-tag struct: data, first, last, pad.
  - localparam helpers: window counts, $clog2 counter widths.
- Sub-module conv_skid_fifo: 2-entry FIFO with push, pop, count and tag payload.

Test Plan:
- RAM preloaded with mem[i]=i (IMG_W=IMG_H=8, K=3), start pulse, pix_ready=1.
  - First window = 0,1,2,8,9,10,16,17,18, first tag on 0, last tag on 18.
  - Last window = 45,46,47,53,54,55,61,62,63.
  - 324 beats total, no idle cycles between beats; done pulses once; busy falls with done.
- Same image, pix_ready pseudo-random at 30% duty -> identical 324-beat sequence; in-flight reads never exceed 1; buffer never exceeds 2 entries; payload stable while stalled.
- Reset asserted on beat 50 -> all outputs return to reset values immediately. A subsequent start replays the frame from value 0.
- start pulsed again while busy, and in the same cycle as done -> both ignored; exactly one frame produced.
- ram_wr observed for the whole run -> always 0; ram_en=0 in IDLE, DRAIN and DONE.
- With CONV_WIN_ZERO_PAD_EN -> 576 beats.
  - Window (0,0) = 0,0,0,0,0,1,0,8,9.
  - Window (7,7) = 54,55,0,62,63,0,0,0,0.
  - No RAM reads issued for pad taps.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and elaboration helpers for the convolution window reader.
// The optional zero-padded "same" convolution mode is enabled by defining
// CONV_WIN_ZERO_PAD_EN; without it only fully in-image windows are scanned.
package conv_pkg;

    // Scan controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } conv_state_e;

    // Per-beat tags travelling with each pixel through the read pipeline.
    // The pixel data itself travels alongside, sized by the instantiating block.
    typedef struct packed {
        logic first;
        logic last;
        logic pad;
    } pix_tag_t;

    // Counter width that never collapses to zero bits
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Window positions along one image axis
    function automatic int win_count(input int img, input int k);
`ifdef CONV_WIN_ZERO_PAD_EN
        return img;
`else
        return img - k + 1;
`endif
    endfunction

    // Offset from window origin to the centre tap (zero when not padding)
    function automatic int pad_off(input int k);
`ifdef CONV_WIN_ZERO_PAD_EN
        return (k - 1) / 2;
`else
        return 0;
`endif
    endfunction

    // Total windows per frame
    function automatic int num_windows(input int img_w, input int img_h, input int k);
        return win_count(img_w, k) * win_count(img_h, k);
    endfunction

endpackage

// File: rtl/conv_skid_fifo.sv
// Two-entry FIFO holding returned pixels plus their tags. Its depth matches
// the read credit so one in-flight read can always land.
module conv_skid_fifo
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  pix_tag_t              push_tag,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic [DATA_WIDTH-1:0] head_data,
    output pix_tag_t              head_tag
);

    logic [DATA_WIDTH-1:0] data_r [0:1];
    pix_tag_t              tag_r  [0:1];
    logic                  wr_ptr_r;
    logic                  rd_ptr_r;
    logic [1:0]            count_r;
    logic                  push_ok_s;
    logic                  pop_ok_s;

    // Guard against overflow/underflow even if a caller misbehaves
    always_comb begin
        push_ok_s = push & (count_r != 2'd2);
        pop_ok_s  = pop  & (count_r != 2'd0);
    end

    // Storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                data_r[i] <= {DATA_WIDTH{1'b0}};
                tag_r[i]  <= 3'b000;
            end
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_ok_s) begin
                data_r[wr_ptr_r] <= push_data;
                tag_r[wr_ptr_r]  <= push_tag;
                wr_ptr_r         <= ~wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign count     = count_r;
    assign head_data = data_r[rd_ptr_r];
    assign head_tag  = tag_r[rd_ptr_r];

endmodule

// File: rtl/conv_window_reader.sv
// Walks every KxK window of a row-major image held in a 1-cycle-latency RAM
// and streams the taps out on valid/ready at one pixel per cycle.
// Define CONV_WIN_ZERO_PAD_EN for zero-padded "same" windows (pad taps skip
// the RAM but keep their slot in the stream with data 0).
module conv_window_reader
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int K          = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_en,
    output logic                  ram_wr,
    output logic [ADDR_WIDTH-1:0] ram_address_rd,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_first,
    output logic                  pix_last
);

    localparam int OX_N    = win_count(IMG_W, K);
    localparam int OY_N    = win_count(IMG_H, K);
    localparam int OXW     = cnt_w(OX_N);
    localparam int OYW     = cnt_w(OY_N);
    localparam int KW      = cnt_w(K);
    localparam int PAD_OFF = pad_off(K);

    conv_state_e           state_r;
    conv_state_e           state_next_s;
    logic [OXW-1:0]        ox_r;
    logic [OYW-1:0]        oy_r;
    logic [KW-1:0]         kx_r;
    logic [KW-1:0]         ky_r;
    logic                  infl_r;
    pix_tag_t              infl_tag_r;
    logic                  busy_r;
    logic                  done_r;

    logic [1:0]            fifo_count_s;
    logic [DATA_WIDTH-1:0] head_data_s;
    pix_tag_t              head_tag_s;
    logic                  fifo_valid_s;
    logic                  pop_s;
    logic [2:0]            occ_s;
    logic                  credit_ok_s;
    logic                  issue_s;
    logic                  last_slot_s;
    logic                  pad_s;
    int                    row_s;
    int                    col_s;
    logic [ADDR_WIDTH-1:0] addr_s;
    pix_tag_t              tap_tag_s;

    // Tap coordinate, pad detection, RAM address and tags for the current slot
    always_comb begin
        row_s = int'(oy_r) + int'(ky_r) - PAD_OFF;
        col_s = int'(ox_r) + int'(kx_r) - PAD_OFF;
`ifdef CONV_WIN_ZERO_PAD_EN
        pad_s = (row_s < 0) || (row_s >= IMG_H) || (col_s < 0) || (col_s >= IMG_W);
`else
        pad_s = 1'b0;
`endif
        addr_s          = ADDR_WIDTH'(row_s * IMG_W + col_s);
        tap_tag_s.first = (ky_r == {KW{1'b0}}) && (kx_r == {KW{1'b0}});
        tap_tag_s.last  = (ky_r == KW'(K - 1)) && (kx_r == KW'(K - 1));
        tap_tag_s.pad   = pad_s;
    end

    // Credit: FIFO entries plus the in-flight slot, net of this cycle's pop
    always_comb begin
        fifo_valid_s = (fifo_count_s != 2'd0);
        pop_s        = fifo_valid_s & pix_ready;
        occ_s        = 3'(fifo_count_s) + 3'(infl_r) - 3'(pop_s);
        credit_ok_s  = (occ_s < 3'd2);
        last_slot_s  = (oy_r == OYW'(OY_N - 1)) && (ox_r == OXW'(OX_N - 1)) &&
                       (ky_r == KW'(K - 1)) && (kx_r == KW'(K - 1));
    end

    // Next-state and slot-issue decode
    always_comb begin
        state_next_s = state_r;
        issue_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (credit_ok_s) begin
                    issue_s = 1'b1;
                    if (last_slot_s) begin
                        state_next_s = DRAIN;
                    end else begin
                        state_next_s = RUN;
                    end
                end else begin
                    state_next_s = RUN;
                end
            end
            DRAIN: begin
                // Leave as the last beat is accepted so done follows it directly
                if (!infl_r && ((fifo_count_s == 2'd0) || ((fifo_count_s == 2'd1) && pop_s))) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Registered status flags derived from the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s == RUN) || (state_next_s == DRAIN);
            done_r <= (state_next_s == DONE);
        end
    end

    // Scan counters: kx innermost, then ky, ox, oy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ox_r <= {OXW{1'b0}};
            oy_r <= {OYW{1'b0}};
            kx_r <= {KW{1'b0}};
            ky_r <= {KW{1'b0}};
        end else if ((state_r == IDLE) && start) begin
            ox_r <= {OXW{1'b0}};
            oy_r <= {OYW{1'b0}};
            kx_r <= {KW{1'b0}};
            ky_r <= {KW{1'b0}};
        end else if (issue_s) begin
            if (kx_r == KW'(K - 1)) begin
                kx_r <= {KW{1'b0}};
                if (ky_r == KW'(K - 1)) begin
                    ky_r <= {KW{1'b0}};
                    if (ox_r == OXW'(OX_N - 1)) begin
                        ox_r <= {OXW{1'b0}};
                        if (oy_r == OYW'(OY_N - 1)) begin
                            oy_r <= {OYW{1'b0}};
                        end else begin
                            oy_r <= oy_r + OYW'(1);
                        end
                    end else begin
                        ox_r <= ox_r + OXW'(1);
                    end
                end else begin
                    ky_r <= ky_r + KW'(1);
                end
            end else begin
                kx_r <= kx_r + KW'(1);
            end
        end
    end

    // In-flight slot: its RAM data (or pad marker) lands next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            infl_r     <= 1'b0;
            infl_tag_r <= 3'b000;
        end else begin
            infl_r     <= issue_s;
            infl_tag_r <= tap_tag_s;
        end
    end

    conv_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (infl_r),
        .push_data (ram_dout),
        .push_tag  (infl_tag_r),
        .pop       (pop_s),
        .count     (fifo_count_s),
        .head_data (head_data_s),
        .head_tag  (head_tag_s)
    );

    // Pad taps read nothing; the address is held at 0 whenever no read issues
    assign ram_en         = issue_s & ~pad_s;
    assign ram_wr         = 1'b0;
    assign ram_address_rd = ram_en ? addr_s : {ADDR_WIDTH{1'b0}};

    assign busy      = busy_r;
    assign done      = done_r;
    assign pix_valid = fifo_valid_s;
    assign pix_data  = (fifo_valid_s && !head_tag_s.pad) ? head_data_s : {DATA_WIDTH{1'b0}};
    assign pix_first = fifo_valid_s & head_tag_s.first;
    assign pix_last  = fifo_valid_s & head_tag_s.last;

endmodule

// File: tb/tb_conv_window_reader.sv
// Directed bench for conv_window_reader on an 8x8 image with a 3x3 kernel.
// RAM holds mem[i]=i; expected beats follow the raster window scan.
module tb_conv_window_reader;

    localparam int DW = 8;
    localparam int AW = 6;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int KK = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic          ram_en;
    logic          ram_wr;
    logic [AW-1:0] ram_address_rd;
    logic [DW-1:0] ram_dout;
    logic          pix_valid;
    logic          pix_ready;
    logic [DW-1:0] pix_data;
    logic          pix_first;
    logic          pix_last;

    logic [DW-1:0] mem [0:63];

    int n_assert = 0;
    int n_fail   = 0;

    int exp_data[$];
    int exp_first[$];
    int exp_last[$];
    int exp_addr[$];
    int obs_data[$];

    always #5 clk = ~clk;

    // RAM model: registered read data, one cycle latency
    always @(posedge clk) begin
        if (ram_en) ram_dout <= mem[ram_address_rd];
    end

    conv_window_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .IMG_W      (W),
        .IMG_H      (H),
        .K          (KK)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .ram_en         (ram_en),
        .ram_wr         (ram_wr),
        .ram_address_rd (ram_address_rd),
        .ram_dout       (ram_dout),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .pix_data       (pix_data),
        .pix_first      (pix_first),
        .pix_last       (pix_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void build_expected();
        int p, nx, ny, r, c, pad;
`ifdef CONV_WIN_ZERO_PAD_EN
        p = (KK - 1) / 2; nx = W; ny = H;
`else
        p = 0; nx = W - KK + 1; ny = H - KK + 1;
`endif
        for (int oy = 0; oy < ny; oy++)
            for (int ox = 0; ox < nx; ox++)
                for (int ky = 0; ky < KK; ky++)
                    for (int kx = 0; kx < KK; kx++) begin
                        r   = oy + ky - p;
                        c   = ox + kx - p;
                        pad = (r < 0 || r >= H || c < 0 || c >= W) ? 1 : 0;
                        exp_data.push_back(pad ? 0 : r * W + c);
                        exp_first.push_back((ky == 0 && kx == 0) ? 1 : 0);
                        exp_last.push_back((ky == KK - 1 && kx == KK - 1) ? 1 : 0);
                        if (!pad) exp_addr.push_back(r * W + c);
                    end
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_ram_en"}, ram_en, 0);
        chk({tag, "_addr"},  ram_address_rd, 0);
        chk({tag, "_valid"}, pix_valid, 0);
        chk({tag, "_data"},  pix_data, 0);
        chk({tag, "_first"}, pix_first, 0);
        chk({tag, "_last"},  pix_last, 0);
    endtask

    // One frame: start at cycle 0, optional extra starts, optional abort by reset
    task automatic run_frame(input int duty, input bit extra_start, input int abort_beat,
                             input bit timing_checks);
        int c = 0, beat = 0, rd = 0;
        int first_vc = -1, first_c = -1, last_c = -1, done_c = -1, done_cnt = 0;
        bit prv_valid = 1'b0, prv_ready = 1'b0, prv_first = 1'b0, prv_last = 1'b0;
        bit prev_busy = 1'b0, rdy, d, finished = 1'b0, aborted = 1'b0;
        logic [DW-1:0] prv_data = '0;
        obs_data.delete();
        while (!finished) begin
            @(negedge clk);
            d = done;
            rdy = (duty >= 100) ? 1'b1 : ($urandom_range(99) < duty);
            pix_ready = rdy;
            start = (c == 0) || (extra_start && (c == 20 || d));
            #1;
            chk("ram_wr", ram_wr, 0);
`ifndef CONV_WIN_ZERO_PAD_EN
            chk("occupancy_le2", (rd - beat <= 2), 1);
`endif
            if (ram_en) begin
                chk("ram_en_busy", busy, 1);
                if (rd < exp_addr.size()) chk("read_addr", ram_address_rd, exp_addr[rd]);
                else chk("extra_read", ram_en, 0);
                rd++;
            end
            if (prv_valid && !prv_ready) begin
                chk("stall_valid", pix_valid, 1);
                chk("stall_data", pix_data, prv_data);
                chk("stall_first", pix_first, prv_first);
                chk("stall_last", pix_last, prv_last);
            end
            if (pix_valid && first_vc < 0) first_vc = c;
            if (pix_valid && rdy) begin
                if (beat < exp_data.size()) begin
                    chk("beat_data", pix_data, exp_data[beat]);
                    chk("beat_first", pix_first, exp_first[beat]);
                    chk("beat_last", pix_last, exp_last[beat]);
                end else begin
                    chk("extra_beat", pix_valid, 0);
                end
                obs_data.push_back(int'(pix_data));
                if (first_c < 0) first_c = c;
                last_c = c;
                beat++;
            end
            if (d) begin
                done_cnt++;
                done_c = c;
                chk("done_busy_low", busy, 0);
                chk("busy_before_done", prev_busy, 1);
                chk("done_beats", beat, exp_data.size());
            end else if (done_cnt > 0) begin
                chk("idle_after_done", busy, 0);
            end
            prv_valid = pix_valid; prv_ready = rdy; prv_data = pix_data;
            prv_first = pix_first; prv_last = pix_last; prev_busy = busy;
            if (abort_beat > 0 && beat == abort_beat) begin
                rst_n = 1'b0;
                #1;
                check_reset("abort");
                aborted = 1'b1;
                finished = 1'b1;
            end else if (done_cnt > 0 && c >= done_c + 10) begin
                finished = 1'b1;
            end else if (c >= 5000) begin
                chk("timeout_done_seen", done_cnt, 1);
                finished = 1'b1;
            end
            c++;
        end
        start = 1'b0;
        if (!aborted) begin
            chk("done_count", done_cnt, 1);
            chk("beat_count", beat, exp_data.size());
            chk("read_count", rd, exp_addr.size());
            if (timing_checks) begin
                chk("latency", first_vc, 3);
                chk("no_gaps", last_c - first_c, exp_data.size() - 1);
                chk("done_after_last", done_c, last_c + 1);
            end
        end
    endtask

    initial begin
        int fw[9];
        int lw[9];
        int n;
`ifdef CONV_WIN_ZERO_PAD_EN
        fw = '{0, 0, 0, 0, 0, 1, 0, 8, 9};
        lw = '{54, 55, 0, 62, 63, 0, 0, 0, 0};
`else
        fw = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
        lw = '{45, 46, 47, 53, 54, 55, 61, 62, 63};
`endif
        for (int i = 0; i < 64; i++) mem[i] = DW'(i);
        ram_dout  = '0;
        rst_n     = 1'b0;
        start     = 1'b0;
        pix_ready = 1'b0;
        build_expected();

        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset("post_reset");

        // Full-rate frame with stray starts while busy and on the done pulse
        run_frame(100, 1'b1, 0, 1'b1);
        n = obs_data.size();
        for (int i = 0; i < 9; i++) begin
            if (i < n) chk("first_window", obs_data[i], fw[i]);
            if (n - 9 + i >= 0) chk("last_window", obs_data[n - 9 + i], lw[i]);
        end

        // Backpressured frame, ready at about 30% duty
        run_frame(30, 1'b0, 0, 1'b0);

        // Abort on beat 50, then replay the frame from the beginning
        run_frame(100, 1'b0, 50, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(100, 1'b0, 0, 1'b1);
        if (obs_data.size() > 0) chk("replay_first", obs_data[0], fw[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
